// File: rtl/dst_bf16_pack.sv
// dst_bf16_pack: FP32 -> bfloat16 (round-to-nearest-even) with optional ReLU,
// packing two bf16 results per 32-bit output word. Registered output with
// back-pressure; packet boundaries are never crossed inside one word.
module dst_bf16_pack #(
    parameter int unsigned PACK_LO_FIRST = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             relu,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             m_valid,
    output logic [31:0]      m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] word_cnt,
    output logic             nan_seen,
    output logic             ovf_seen
);

    logic             r_m_valid;
    logic [31:0]      r_m_data;
    logic             r_m_last;
    logic             r_half_v;
    logic [15:0]      r_half_d;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_nan_seen;
    logic             r_ovf_seen;

    logic             w_exp_ones;
    logic             w_is_nan;
    logic [31:0]      w_rnd;
    logic [15:0]      w_bf;
    logic             w_ovf;
    logic             w_accept;
    logic             w_emit;
    logic             w_drain;
    logic [15:0]      w_first;
    logic [15:0]      w_second;
    logic [31:0]      w_word;

    // Element conversion: NaN canonicalisation, RNE rounding, then ReLU.
    always_comb begin
        w_exp_ones = (s_data[30:23] == 8'hFF);
        w_is_nan   = w_exp_ones && (s_data[22:0] != 23'd0);
        // Adding 0x7FFF plus the kept LSB rounds half-way cases to even.
        w_rnd      = s_data + 32'h0000_7FFF + {31'd0, s_data[16]};
        w_ovf      = !w_exp_ones && (w_rnd[30:23] == 8'hFF);
        if (w_is_nan) begin
            w_bf = 16'h7FC0;
        end else if (relu && s_data[31]) begin
            w_bf = 16'h0000;
        end else begin
            w_bf = w_rnd[31:16];
        end
    end

    // Handshake decode and word assembly for the completing accept.
    always_comb begin
        s_ready  = !r_m_valid || m_ready;
        w_accept = s_valid && s_ready;
        w_emit   = w_accept && (r_half_v || s_last);
        w_drain  = r_m_valid && m_ready;
        w_first  = r_half_v ? r_half_d : w_bf;
        w_second = r_half_v ? w_bf : 16'h0000;
        if (PACK_LO_FIRST != 0) begin
            w_word = {w_second, w_first};
        end else begin
            w_word = {w_first, w_second};
        end
    end

    // Packing state, output register, word counter and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid  <= 1'b0;
            r_m_data   <= 32'd0;
            r_m_last   <= 1'b0;
            r_half_v   <= 1'b0;
            r_half_d   <= 16'd0;
            r_word_cnt <= '0;
            r_nan_seen <= 1'b0;
            r_ovf_seen <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_half_v) begin
                    r_half_v <= 1'b0;
                end else if (!s_last) begin
                    r_half_v <= 1'b1;
                    r_half_d <= w_bf;
                end
                if (w_is_nan) begin
                    r_nan_seen <= 1'b1;
                end
                if (w_ovf) begin
                    r_ovf_seen <= 1'b1;
                end
            end
            // A new word overrides a same-cycle drain, so there is no bubble.
            if (w_emit) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_word;
                r_m_last  <= r_half_v ? s_last : 1'b1;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (w_drain) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_last   = r_m_last;
    assign word_cnt = r_word_cnt;
    assign nan_seen = r_nan_seen;
    assign ovf_seen = r_ovf_seen;

endmodule

// File: tb/tb_dst_bf16_pack.sv
// Self-checking bench for dst_bf16_pack: an element-level model builds the
// expected word stream; a per-cycle monitor checks every delivered word.
module tb_dst_bf16_pack;

    logic        clk;
    logic        rst;
    logic        relu;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;
    logic [15:0] word_cnt;
    logic        nan_seen;
    logic        ovf_seen;

    int tests;
    int fails;
    int stall_cnt;

    // Model state
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    bit          mdl_half;
    logic [15:0] mdl_half_d;
    int          mdl_words;
    bit          mdl_nan;
    bit          mdl_ovf;

    // Monitor state
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    dst_bf16_pack #(
        .PACK_LO_FIRST(1),
        .CNT_W        (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .relu    (relu),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_ready (m_ready),
        .word_cnt(word_cnt),
        .nan_seen(nan_seen),
        .ovf_seen(ovf_seen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input bit ok, input string name, input logic [32:0] act,
                       input logic [32:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Round-to-nearest-even of the upper half, by inspecting the dropped bits.
    function automatic logic [15:0] rne(input logic [31:0] x);
        logic [15:0] up;
        logic [15:0] lo;
        up = x[31:16];
        lo = x[15:0];
        if (lo > 16'h8000 || (lo == 16'h8000 && up[0])) up = up + 16'd1;
        return up;
    endfunction

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic bit rounds_to_inf(input logic [31:0] x);
        logic [15:0] r;
        r = rne(x);
        return (x[30:23] != 8'hFF) && (r[14:7] == 8'hFF);
    endfunction

    function automatic logic [15:0] conv(input logic [31:0] x, input bit r);
        if (is_nan(x)) return 16'h7FC0;
        if (r && x[31]) return 16'h0000;
        return rne(x);
    endfunction

    function automatic logic [32:0] mkword(input logic [15:0] first, input logic [15:0] second,
                                           input bit last);
        return {last, second, first};
    endfunction

    task automatic model_accept(input logic [31:0] d, input bit l, input bit r);
        logic [15:0] bf;
        bf = conv(d, r);
        if (is_nan(d)) mdl_nan = 1;
        if (rounds_to_inf(d)) mdl_ovf = 1;
        if (mdl_half) begin
            exp_q.push_back(mkword(mdl_half_d, bf, l));
            mdl_words++;
            mdl_half = 0;
        end else if (l) begin
            exp_q.push_back(mkword(bf, 16'h0000, 1'b1));
            mdl_words++;
        end else begin
            mdl_half   = 1;
            mdl_half_d = bf;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        obs_q.delete();
        mdl_half  = 0;
        mdl_words = 0;
        mdl_nan   = 0;
        mdl_ovf   = 0;
    endtask

    // Offer one element until accepted (bounded).
    task automatic send(input logic [31:0] d, input bit l, input bit r);
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = d;
            s_last  = l;
            relu    = r;
            #1;
            if (s_ready) begin
                model_accept(d, l, r);
                done = 1;
            end else begin
                stall_cnt++;
            end
        end
        chk(done, "send_timeout", {32'd0, done}, 33'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #3;
        end
        chk(exp_q.size() == 0, "drain_timeout", 33'(exp_q.size()), 33'd0);
        @(negedge clk);
        #3;
    endtask

    task automatic check_obs(input int idx, input logic [32:0] req, input string name);
        if (idx < obs_q.size()) chk(obs_q[idx] === req, name, obs_q[idx], req);
        else chk(1'b0, name, 33'h0, req);
    endtask

    // Per-cycle monitor: handshake rule, hold-while-stalled, word scoreboard.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 0;
        end else begin
            chk(s_ready === (!m_valid || m_ready), "s_ready_rule", {32'd0, s_ready},
                {32'd0, !m_valid || m_ready});
            if (prev_stall) begin
                chk(m_valid && m_data === prev_data && m_last === prev_last, "hold_stable",
                    {m_last, m_data}, {prev_last, prev_data});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_word", {m_last, m_data}, 33'h0);
                end else begin
                    chk({m_last, m_data} === exp_q[0], "word", {m_last, m_data}, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                obs_q.push_back({m_last, m_data});
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        stall_cnt = 0;
        rst = 1'b1;
        relu = 1'b0;
        s_valid = 1'b0;
        s_data = 32'd0;
        s_last = 1'b0;
        m_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        // Reset state
        chk(!m_valid && m_data == 0 && !m_last, "reset_out", {m_last, m_data}, 33'h0);
        chk(word_cnt == 0 && !nan_seen && !ovf_seen, "reset_status",
            {15'd0, word_cnt, nan_seen, ovf_seen}, 33'h0);

        // Pin the model to hand-computed conversions.
        chk(conv(32'h3F808000, 0) == 16'h3F80, "pin_tie_even", 33'(conv(32'h3F808000, 0)),
            33'h3F80);
        chk(conv(32'h3F818000, 0) == 16'h3F82, "pin_tie_up", 33'(conv(32'h3F818000, 0)),
            33'h3F82);
        chk(conv(32'h7F7FFFFF, 0) == 16'h7F80 && rounds_to_inf(32'h7F7FFFFF), "pin_ovf",
            33'(conv(32'h7F7FFFFF, 0)), 33'h7F80);
        chk(conv(32'h7FC00001, 1) == 16'h7FC0, "pin_nan", 33'(conv(32'h7FC00001, 1)),
            33'h7FC0);

        // Rounding
        send(32'h3F800000, 0, 0);
        send(32'h3F808000, 0, 0);
        send(32'h3F818000, 0, 0);
        send(32'h3F808001, 1, 0);
        idle();
        drain();
        chk(obs_q.size() == 2, "round_count", 33'(obs_q.size()), 33'd2);
        check_obs(0, {1'b0, 32'h3F803F80}, "round_w0");
        check_obs(1, {1'b1, 32'h3F813F82}, "round_w1");
        chk(word_cnt == 16'd2, "round_cnt", 33'(word_cnt), 33'd2);
        obs_q.delete();

        // Odd packet with pad
        send(32'h3F800000, 0, 0);
        send(32'h40000000, 0, 0);
        send(32'hBF800000, 1, 0);
        idle();
        drain();
        check_obs(0, {1'b0, 32'h40003F80}, "odd_w0");
        check_obs(1, {1'b1, 32'h0000BF80}, "odd_pad");
        obs_q.delete();

        // ReLU and specials
        send(32'hC0000000, 0, 1);
        send(32'h80000000, 0, 1);
        send(32'h7FC00001, 0, 1);
        send(32'h7F7FFFFF, 1, 1);
        idle();
        drain();
        check_obs(0, {1'b0, 32'h00000000}, "relu_w0");
        check_obs(1, {1'b1, 32'h7F807FC0}, "relu_w1");
        chk(nan_seen && ovf_seen, "sticky_set", {31'd0, nan_seen, ovf_seen}, 33'd3);
        chk(nan_seen == mdl_nan && ovf_seen == mdl_ovf, "sticky_model",
            {31'd0, nan_seen, ovf_seen}, {31'd0, mdl_nan, mdl_ovf});
        chk(word_cnt == 16'(mdl_words), "cnt_model", 33'(word_cnt), 33'(mdl_words));
        obs_q.delete();

        // Back-pressure: stall the first word for 3 cycles.
        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(32'h3F800000 + (i << 16), i == 7, 0);
                idle();
            end
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (m_valid) seen = 1;
                end
                m_ready = 1'b0;
                repeat (3) @(negedge clk);
                m_ready = 1'b1;
                chk(seen, "bp_first_word", {32'd0, seen}, 33'd1);
            end
        join
        drain();
        chk(stall_cnt > 0, "bp_stalled", 33'(stall_cnt), 33'd1);
        chk(obs_q.size() == 4, "bp_count", 33'(obs_q.size()), 33'd4);
        check_obs(0, {1'b0, 32'h3F813F80}, "bp_w0");
        check_obs(3, {1'b1, 32'h3F873F86}, "bp_w3");
        obs_q.delete();

        // Emit and drain in the same cycle: no stalls at 1 element/cycle.
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) send(32'h40000000 + (i << 16), i == 7, 0);
        idle();
        drain();
        chk(stall_cnt == 0, "stream_nostall", 33'(stall_cnt), 33'd0);
        chk(obs_q.size() == 4, "stream_count", 33'(obs_q.size()), 33'd4);
        check_obs(1, {1'b0, 32'h40034002}, "stream_w1");
        obs_q.delete();

        // Reset mid-packet discards the held half and clears status.
        send(32'h40400000, 0, 0);
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk(word_cnt == 0 && !nan_seen && !ovf_seen && !m_valid, "midrst_clear",
            {14'd0, word_cnt, nan_seen, ovf_seen, m_valid}, 33'h0);
        send(32'h3F800000, 1, 0);
        idle();
        drain();
        chk(obs_q.size() == 1, "midrst_count", 33'(obs_q.size()), 33'd1);
        check_obs(0, {1'b1, 32'h00003F80}, "midrst_w0");
        chk(word_cnt == 16'd1, "midrst_cnt", 33'(word_cnt), 33'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
